// File: rtl/stream_mux2_if.sv
// Handshake bundle for stream_mux2: two valid/ready producers and one registered output channel.
// slave = the mux side, master = the producer/consumer side.
interface stream_mux2_if #(
    parameter int unsigned DW = 2
);
    logic          in0_valid;
    logic          in0_ready;
    logic [DW-1:0] in0_data;
    logic          in0_last;
    logic          in1_valid;
    logic          in1_ready;
    logic [DW-1:0] in1_data;
    logic          in1_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_sel;

    modport slave (
        input  in0_valid, in0_data, in0_last,
        input  in1_valid, in1_data, in1_last,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in0_valid, in0_data, in0_last,
        output in1_valid, in1_data, in1_last,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/stream_mux2.sv
// Round-robin 2:1 stream merge into a one-entry output register, tagging each beat with its source.
// Optional packet lock (holds the grant until the granted input's last beat): define STREAM_MUX_LOCK_EN.
module stream_mux2 #(
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_mux2_if.slave  bus
);

`ifdef STREAM_MUX_LOCK_EN
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED0  = 2'd1,
        ST_LOCKED1  = 2'd2
    } lock_e;

    lock_e r_lock;
`endif

    logic          r_rr;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_out_sel;

    logic          w_load_en;
    logic          w_grant;
    logic          w_accept;
    logic [DW-1:0] w_sel_data;
    logic          w_sel_last;

    // Grant: sole valid input wins, ties (and idle) go to the input not served last.
    always_comb begin
        w_grant = ~r_rr;
        if (bus.in0_valid && !bus.in1_valid) begin
            w_grant = 1'b0;
        end else if (bus.in1_valid && !bus.in0_valid) begin
            w_grant = 1'b1;
        end
`ifdef STREAM_MUX_LOCK_EN
        if (r_lock == ST_LOCKED0) begin
            w_grant = 1'b0;
        end else if (r_lock == ST_LOCKED1) begin
            w_grant = 1'b1;
        end
`endif
    end

    assign w_load_en     = !r_out_valid || bus.out_ready;
    assign bus.in0_ready = w_load_en && !w_grant;
    assign bus.in1_ready = w_load_en &&  w_grant;
    assign w_accept      = w_load_en && (w_grant ? bus.in1_valid : bus.in0_valid);
    assign w_sel_data    = w_grant ? bus.in1_data : bus.in0_data;
    assign w_sel_last    = w_grant ? bus.in1_last : bus.in0_last;

    // Output register and round-robin pointer; drain and reload in one cycle keeps full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= 1'b0;
        end else if (w_accept) begin
            r_rr        <= w_grant;
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_sel   <= w_grant;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    // Lock on a non-last accepted beat, release on the locked input's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= ST_UNLOCKED;
        end else if (w_accept) begin
            case (r_lock)
                ST_UNLOCKED: if (!w_sel_last) r_lock <= w_grant ? ST_LOCKED1 : ST_LOCKED0;
                ST_LOCKED0,
                ST_LOCKED1:  if (w_sel_last)  r_lock <= ST_UNLOCKED;
                default:     r_lock <= ST_UNLOCKED;
            endcase
        end
    end
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux2.sv
// Self-checking bench for stream_mux2: reference arbiter model feeding a scoreboard of expected output beats.
// Build with or without STREAM_MUX_LOCK_EN; the lock scenario expects the matching source order.
module tb_stream_mux2;
    localparam int unsigned DW = 2;
    localparam int unsigned BW = DW + 2;

    logic clk;
    logic rst_n;

    stream_mux2_if #(.DW(DW)) bus ();

    stream_mux2 #(.DW(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic            m_rr;
    logic            m_ov;
    int              m_lock;      // 0 unlocked, 1 locked on input 0, 2 locked on input 1
    logic            m_acc;
    logic            m_g;
    logic [BW-1:0]   sb_q[$];     // {sel, last, data}
    logic [DW:0]     drain_log[$]; // {sel, data}

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_grant(input logic v0, input logic v1);
        logic g;
        g = ~m_rr;
        if (v0 && !v1) g = 1'b0;
        else if (v1 && !v0) g = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        if (m_lock == 1) g = 1'b0;
        else if (m_lock == 2) g = 1'b1;
`endif
        return g;
    endfunction

    task automatic drive_idle();
        bus.in0_valid = 1'b0; bus.in0_data = '0; bus.in0_last = 1'b0;
        bus.in1_valid = 1'b0; bus.in1_data = '0; bus.in1_last = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check_eq("rst_out_data",  32'(bus.out_data),  32'(0));
        check_eq("rst_out_last",  32'(bus.out_last),  32'(0));
        check_eq("rst_out_sel",   32'(bus.out_sel),   32'(0));
        m_rr = 1'b1; m_ov = 1'b0; m_lock = 0;
        sb_q.delete();
        drain_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check handshake and output against the model, advance model.
    task automatic step(input logic v0, input logic [DW-1:0] d0, input logic l0,
                        input logic v1, input logic [DW-1:0] d1, input logic l1,
                        input logic ordy);
        logic          ld;
        logic          g;
        logic [BW-1:0] exp;
        @(negedge clk);
        bus.in0_valid = v0; bus.in0_data = d0; bus.in0_last = l0;
        bus.in1_valid = v1; bus.in1_data = d1; bus.in1_last = l1;
        bus.out_ready = ordy;
        #1;
        ld = !m_ov || ordy;
        g  = model_grant(v0, v1);
        check_eq("in0_ready", 32'(bus.in0_ready), 32'(ld && !g));
        check_eq("in1_ready", 32'(bus.in1_ready), 32'(ld && g));
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(1), 32'(0));
            end else begin
                exp = sb_q[0];
                check_eq("out_beat", 32'({bus.out_sel, bus.out_last, bus.out_data}), 32'(exp));
                if (ordy) begin
                    void'(sb_q.pop_front());
                    drain_log.push_back({bus.out_sel, bus.out_data});
                end
            end
        end
        m_acc = ld && (g ? v1 : v0);
        m_g   = g;
        if (m_acc) begin
            sb_q.push_back(g ? {1'b1, l1, d1} : {1'b0, l0, d0});
            m_rr = g;
            m_ov = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
            if (m_lock == 0 && !(g ? l1 : l0)) m_lock = g ? 2 : 1;
            else if (m_lock != 0 && (g ? l1 : l0)) m_lock = 0;
`endif
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        drive_idle();
        m_rr = 1'b1; m_ov = 1'b0; m_lock = 0; m_acc = 1'b0; m_g = 1'b0;
        do_reset();

        // Single input, idle output
        step(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("t1_data", 32'(drain_log.size() > 0 ? drain_log[0] : 3'b111), 32'(3'b001));

        // Tie after reset alternates starting with input 0
        do_reset();
        repeat (4) step(1'b1, 2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("tie_count", 32'(drain_log.size()), 32'(4));
        if (drain_log.size() == 4) begin
            check_eq("tie_beat0", 32'(drain_log[0]), 32'(3'b010));
            check_eq("tie_beat1", 32'(drain_log[1]), 32'(3'b111));
            check_eq("tie_beat2", 32'(drain_log[2]), 32'(3'b010));
            check_eq("tie_beat3", 32'(drain_log[3]), 32'(3'b111));
        end

        // Backpressure: held beat stays, both readies low, then no-gap reload
        do_reset();
        step(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
        check_eq("bp_hold_data", 32'(bus.out_data), 32'(2'b01));
        step(1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("bp_next_sel",  32'(bus.out_sel),  32'(1));
        check_eq("bp_next_data", 32'(bus.out_data), 32'(2'b10));

        // Simultaneous drain and load
        step(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("dl_valid", 32'(bus.out_valid), 32'(1));
        check_eq("dl_data",  32'(bus.out_data),  32'(2'b11));

        // Packet lock scenario: input 0 sends 3 beats while input 1 stays valid
        do_reset();
        idx = 0;
        for (int c = 0; c < 20 && drain_log.size() < 4; c++) begin
            step(idx < 3, DW'(idx), idx == 2, 1'b1, 2'b11, 1'b1, 1'b1);
            if (m_acc && !m_g) idx++;
        end
        check_eq("lock_done", 32'(drain_log.size() >= 4), 32'(1));
        if (drain_log.size() >= 4) begin
`ifdef STREAM_MUX_LOCK_EN
            check_eq("lock_src0", 32'(drain_log[0][DW]), 32'(0));
            check_eq("lock_src1", 32'(drain_log[1][DW]), 32'(0));
            check_eq("lock_src2", 32'(drain_log[2][DW]), 32'(0));
            check_eq("lock_src3", 32'(drain_log[3][DW]), 32'(1));
`else
            check_eq("lock_src0", 32'(drain_log[0][DW]), 32'(0));
            check_eq("lock_src1", 32'(drain_log[1][DW]), 32'(1));
            check_eq("lock_src2", 32'(drain_log[2][DW]), 32'(0));
            check_eq("lock_src3", 32'(drain_log[3][DW]), 32'(1));
`endif
        end

        // Reset mid-stall drops the held beat; tie afterwards grants input 0
        step(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("post_rst_sel",  32'(bus.out_sel),  32'(0));
        check_eq("post_rst_data", 32'(bus.out_data), 32'(2'b10));

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom), DW'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), DW'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) != 0));
        end
        repeat (2) step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("sb_empty_end", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_mux2.md
# stream_mux2

- Two-input, one-output streaming multiplexer: the merge counterpart of the 1:2 demux datapath.
- Two valid/ready producers feed one registered output channel.
- Round-robin arbitration between the inputs; the output carries a source tag (`out_sel`) so a downstream demux can split the stream again.
- Optional packet lock keeps the grant on one input until that input's last beat.

## Interface
Parameters:
- `DW`, default 2: data width of every data port.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_valid`  in  1  input 0 beat valid.
- `in0_ready`  out  1  input 0 beat accepted this cycle when high together with `in0_valid`.
- `in0_data`  in  DW  input 0 payload.
- `in0_last`  in  1  input 0 end-of-packet marker.
- `in1_valid`, `in1_ready`, `in1_data`, `in1_last`: same as input 0, for input 1.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DW  registered payload.
- `out_last`  out  1  registered last marker.
- `out_sel`  out  1  source of the current beat: 0 = input 0, 1 = input 1.

## Operation
- Output stage is a one-entry register (`out_valid`, `out_data`, `out_last`, `out_sel`).
- `load_en = !out_valid || out_ready`. Input handshakes are only possible when `load_en` is high.
- **Arbitration**
  - State is `rr_ptr`, the last granted input.
  - Only one input valid: that input is granted.
  - Both valid: grant `!rr_ptr`.
  - `rr_ptr` updates to the granted input on every accepted beat only; it is unchanged when no beat is accepted.
- **Ready**
  - `inK_ready = load_en && (grant == K)`, combinational.
  - `inK_ready` never asserts for the non-granted input.
  - `inK_ready` may assert while `inK_valid` is low, only when that input is the sole eligible one.
  - Without the lock feature, the default grant when neither input is valid is `!rr_ptr`.
- **Accept**
  - On an accepted beat: `out_valid <= 1`, `out_data/out_last <= inK_data/inK_last`, `out_sel <= K`.
- **Drain**
  - `out_valid && out_ready` with no new accept: `out_valid <= 0`.
  - Data, last and sel hold their last values.
- **Simultaneous events**
  - Output drained and new beat accepted in the same cycle: register reloads and `out_valid` stays 1.
  - Result is back-to-back beats at full throughput.
- Input data is ignored when `valid` is low. `out_data` changes only on an accept.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `out_*` after edge N.
- Throughput is 1 beat/cycle while `out_ready` stays high.
- Backpressure: while `out_valid && !out_ready`, both `in*_ready` = 0 and the output holds stable.
- Fairness: with both inputs continuously valid and `out_ready` = 1, output sources alternate 0,1,0,1…
- **Reset** (asynchronous assert, synchronous release):
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_sel` = 0.
  - `rr_ptr` = 1, so input 0 wins the first tie.
  - Lock state = unlocked.
  - Reset mid-packet or mid-stall drops the held beat with no further output.
  - The first cycle after release behaves as idle.

## Configuration
- Macro: `STREAM_MUX_LOCK_EN`.
- **Defined**
  - Lock state machine with states UNLOCKED and LOCKED(K).
  - UNLOCKED -> LOCKED(K) on an accepted beat from K with `inK_last` = 0.
  - LOCKED(K) -> UNLOCKED on an accepted beat from K with `inK_last` = 1.
  - In LOCKED(K), grant is forced to K:
    - The other input's ready stays 0 even if K is idle.
    - `rr_ptr` still updates normally.
  - A single-beat packet (`last` = 1 on the first beat) never enters LOCKED.
- **Undefined**
  - No lock logic; `in*_last` is only passed through to `out_last`.
  - Arbitration is per beat.

## Test plan
- **Single input, idle output**
  - Stimulus: reset, then `in0_valid` = 1, `in0_data` = 2'b01, `out_ready` = 1.
  - Response: `in0_ready` = 1 the same cycle; next cycle `out_valid` = 1, `out_data` = 01, `out_sel` = 0.
- **Tie after reset**
  - Stimulus: both valid, `in0_data` = 2'b10, `in1_data` = 2'b11, `out_ready` = 1 for 4 cycles.
  - Response: output sequence 10/sel0, 11/sel1, 10/sel0, 11/sel1.
- **Backpressure**
  - Stimulus: `out_ready` = 0 for 3 cycles while `in1_valid` = 1 with a beat held.
  - Response: `in0_ready` = `in1_ready` = 0 and `out_data` stable. `out_ready` = 1 then loads the next beat with no gap.
- **Simultaneous drain and load**
  - Stimulus: `out_valid` = 1, `out_ready` = 1, `in0_valid` = 1.
  - Response: `out_valid` stays 1 and the data updates the next cycle.
- **Lock (with `STREAM_MUX_LOCK_EN`)**
  - Stimulus: input 0 sends 3 beats with last = 0,0,1 while input 1 is continuously valid.
  - Response: `in1_ready` = 0 until input 0's last beat is accepted; input 1's beat follows immediately.
  - Without the macro, the same stimulus alternates sources per beat.
- **Reset mid-stall**
  - Stimulus: `rst_n` low while `out_valid` = 1 and `out_ready` = 0.
  - Response: all outputs 0 asynchronously.
  - After release, a tie grants input 0 first.
